prbs_tx_gen: RTL and testbench

//  PRBS pattern source feeding the PRBS receiver/checker (dout/dout_vld -> din/din_vld).

---
 rtl/prbs_pkg.sv | 65 ++++++
 rtl/prbs_tx_gen_if.sv | 32 +++
 rtl/prbs_lfsr.sv | 40 ++++
 rtl/prbs_tx_gen.sv | 164 ++++++++++++++++
 tb/tb_prbs_tx_gen.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_pkg
// Description : Shared PRBS definitions for generator and checker: pattern
//               type encodings, LFSR length per type, Fibonacci tap table,
//               pattern period, and generator FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

  typedef enum logic [2:0] {
    PRBS3  = 3'd0,
    PRBS7  = 3'd1,
    PRBS9  = 3'd2,
    PRBS11 = 3'd3,
    PRBS15 = 3'd4,
    PRBS17 = 3'd5,
    PRBS23 = 3'd6,
    PRBS32 = 3'd7
  } prbs_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } tx_state_e;

  // LFSR length N for a pattern type
  function automatic int unsigned prbs_len(input int unsigned t);
    case (t)
      0:       prbs_len = 3;
      1:       prbs_len = 7;
      2:       prbs_len = 9;
      3:       prbs_len = 11;
      4:       prbs_len = 15;
      5:       prbs_len = 17;
      6:       prbs_len = 23;
      default: prbs_len = 32;
    endcase
  endfunction

  // Pattern period 2^N-1; doubles as the N-bit state mask
  function automatic logic [31:0] prbs_period(input int unsigned t);
    if (prbs_len(t) >= 32)
      prbs_period = 32'hFFFF_FFFF;
    else
      prbs_period = (32'd1 << prbs_len(t)) - 32'd1;
  endfunction

  // Feedback bit; S[0] is the newest bit in the register
  function automatic logic prbs_fb(input logic [31:0] s, input int unsigned t);
    case (t)
      0:       prbs_fb = s[2]  ^ s[0];
      1:       prbs_fb = s[6]  ^ s[0];
      2:       prbs_fb = s[8]  ^ s[4];
      3:       prbs_fb = s[10] ^ s[8];
      4:       prbs_fb = s[14] ^ s[0];
      5:       prbs_fb = s[16] ^ s[2];
      6:       prbs_fb = s[22] ^ s[17];
      default: prbs_fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_tx_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : prbs_tx_gen_if
// Description : Control and output bundle of the PRBS generator. The master
//               side is the generator, the slave side its controller/sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface prbs_tx_gen_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 start;
  logic                 stop;
  logic                 err_inj;
  logic [15:0]          err_period;
  logic                 dout_vld;
  logic                 dout;
  logic                 seq_start;
  logic                 busy;
  logic [CNT_WIDTH-1:0] tx_cnt;
  logic [CNT_WIDTH-1:0] inj_cnt;

  modport master (
    input  start, stop, err_inj, err_period,
    output dout_vld, dout, seq_start, busy, tx_cnt, inj_cnt
  );

  modport slave (
    output start, stop, err_inj, err_period,
    input  dout_vld, dout, seq_start, busy, tx_cnt, inj_cnt
  );
endinterface
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : prbs_lfsr
// Description : Fibonacci LFSR state register with type-selected feedback.
//               load seeds the register (all-zero forced to 1), step shifts
//               the feedback bit in at position 0.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int unsigned PRBS_TYPE = 7
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic [31:0] seed,
  input  wire logic        step,
  output logic             fb
);
  localparam logic [31:0] c_MASK = prbs_period(PRBS_TYPE);

  logic [31:0] r_s;
  logic [31:0] w_seed_m;

  assign w_seed_m = seed & c_MASK;
  assign fb       = prbs_fb(r_s, PRBS_TYPE);

  // State register: seed load has priority over shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_s <= '0;
    else if (load)
      r_s <= (w_seed_m == 32'd0) ? 32'd1 : w_seed_m;
    else if (step)
      r_s <= {r_s[30:0], fb} & c_MASK;
  end

endmodule
`default_nettype wire

// File: rtl/prbs_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : prbs_tx_gen
// Description : Serial PRBS pattern source. Holds the IDLE/LOAD/RUN control
//               FSM, bit-rate divider, single-shot and periodic error
//               injection, pattern-period marker and bit/injection counters.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_tx_gen
  import prbs_pkg::*;
#(
  parameter int unsigned PRBS_TYPE = 7,
  parameter logic [31:0] SEED      = 32'hFFFF_FFFF,
  parameter int unsigned RATE_DIV  = 1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input wire logic      clk,
  input wire logic      rst,
  prbs_tx_gen_if.master bus
);
  localparam logic [31:0]       c_PERIOD   = prbs_period(PRBS_TYPE);
  localparam int unsigned       c_DIV_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RATE_DIV - 1);

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [c_DIV_W-1:0]   r_div;
  logic [31:0]          r_per_cnt;
  logic [15:0]          r_bit_cnt;
  logic [15:0]          r_err_period_q;
  logic                 r_pending;
  logic                 r_dout_vld;
  logic                 r_dout;
  logic                 r_seq_start;
  logic [CNT_WIDTH-1:0] r_tx_cnt;
  logic [CNT_WIDTH-1:0] r_inj_cnt;

  logic w_load;
  logic w_emit;
  logic w_fb;
  logic w_period_chg;
  logic w_per_hit;
  logic w_inv;

  // Next state: stop beats start; start from any state (re)seeds
  always_comb begin
    w_state_nxt = r_state;
    if (bus.stop)
      w_state_nxt = ST_IDLE;
    else if (bus.start)
      w_state_nxt = ST_LOAD;
    else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LOAD: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A bit goes out only on a divider slot of a RUN cycle that stays in RUN
  assign w_load       = (r_state == ST_LOAD);
  assign w_emit       = (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && (r_div == '0);
  assign w_period_chg = (bus.err_period != r_err_period_q);
  assign w_per_hit    = (bus.err_period != 16'd0) && !w_period_chg &&
                        (r_bit_cnt == bus.err_period - 16'd1);
  // Same-cycle err_inj counts toward the bit leaving now
  assign w_inv        = r_pending | bus.err_inj | w_per_hit;

  prbs_lfsr #(
    .PRBS_TYPE (PRBS_TYPE)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .seed (SEED),
    .step (w_emit),
    .fb   (w_fb)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Rate divider: free-runs 0..RATE_DIV-1 while in RUN, parked at 0 otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_div <= '0;
    else if (r_state != ST_RUN) r_div <= '0;
    else if (r_div == c_DIV_LAST) r_div <= '0;
    else                        r_div <= r_div + c_DIV_W'(1);
  end

  // Single-shot inject request: pulses merge, consumed by the next emitted bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_pending <= 1'b0;
    else if (w_emit)      r_pending <= 1'b0;
    else if (bus.err_inj) r_pending <= 1'b1;
  end

  // Periodic inject bit counter, restarted on seed or any period change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt      <= 16'd0;
      r_err_period_q <= 16'd0;
    end else begin
      r_err_period_q <= bus.err_period;
      if (w_load || w_period_chg || (bus.err_period == 16'd0))
        r_bit_cnt <= 16'd0;
      else if (w_emit)
        r_bit_cnt <= w_per_hit ? 16'd0 : r_bit_cnt + 16'd1;
    end
  end

  // Pattern position counter, 0..2^N-2, drives seq_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_load)
      r_per_cnt <= 32'd0;
    else if (w_emit)
      r_per_cnt <= (r_per_cnt == c_PERIOD - 32'd1) ? 32'd0 : r_per_cnt + 32'd1;
  end

  // Output bit registers; cleared whenever the generator falls back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_vld  <= 1'b0;
      r_dout      <= 1'b0;
      r_seq_start <= 1'b0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_dout_vld  <= 1'b0;
      r_dout      <= 1'b0;
      r_seq_start <= 1'b0;
    end else if (w_emit) begin
      r_dout_vld  <= 1'b1;
      r_dout      <= w_fb ^ w_inv;
      r_seq_start <= (r_per_cnt == 32'd0);
    end else begin
      r_dout_vld  <= 1'b0;
      r_seq_start <= 1'b0;
    end
  end

  // Emitted and inverted bit counters: cleared on seed, held in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_load) begin
      r_tx_cnt  <= '0;
      r_inj_cnt <= '0;
    end else if (w_emit) begin
      r_tx_cnt  <= r_tx_cnt + CNT_WIDTH'(1);
      r_inj_cnt <= r_inj_cnt + CNT_WIDTH'(w_inv);
    end
  end

  assign bus.dout_vld  = r_dout_vld;
  assign bus.dout      = r_dout;
  assign bus.seq_start = r_seq_start;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.tx_cnt    = r_tx_cnt;
  assign bus.inj_cnt   = r_inj_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_tx_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prbs_tx_gen
// Description : Scoreboard bench for prbs_tx_gen. Two generators share one
//               stimulus stream: PRBS3 (seed 7, one bit per clock) and PRBS7
//               (default seed, one bit every 4 clocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_tx_gen;

  typedef struct {
    bit          d;
    bit          s;
    int unsigned t;
    int unsigned i;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, err_inj;
  logic [15:0] err_period;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  prbs_tx_gen_if #(.CNT_WIDTH(32)) bus_a ();
  prbs_tx_gen_if #(.CNT_WIDTH(32)) bus_b ();

  assign bus_a.start = start;  assign bus_a.stop = stop;
  assign bus_a.err_inj = err_inj;  assign bus_a.err_period = err_period;
  assign bus_b.start = start;  assign bus_b.stop = stop;
  assign bus_b.err_inj = err_inj;  assign bus_b.err_period = err_period;

  prbs_tx_gen #(.PRBS_TYPE(0), .SEED(32'd7), .RATE_DIV(1), .CNT_WIDTH(32))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  prbs_tx_gen #(.PRBS_TYPE(1), .SEED(32'hFFFF_FFFF), .RATE_DIV(4), .CNT_WIDTH(32))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [1:0]  vld, dout, seqs, busy;
  logic [31:0] txc  [2];
  logic [31:0] injc [2];
  assign vld  = {bus_b.dout_vld, bus_a.dout_vld};
  assign dout = {bus_b.dout, bus_a.dout};
  assign seqs = {bus_b.seq_start, bus_a.seq_start};
  assign busy = {bus_b.busy, bus_a.busy};
  assign txc[0] = bus_a.tx_cnt;   assign txc[1] = bus_b.tx_cnt;
  assign injc[0] = bus_a.inj_cnt; assign injc[1] = bus_b.inj_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (per DUT d) ----------------
  // Pattern as a bit recurrence: x[n] = x[n-1-ta] ^ x[n-1-tb]; seed fills the history.
  function automatic int nlen(int d);  return (d == 0) ? 3 : 7;  endfunction
  function automatic int tap_a(int d); return (d == 0) ? 2 : 6;  endfunction
  function automatic int tap_b(int d); return 0;                 endfunction
  function automatic int rdiv(int d);  return (d == 0) ? 1 : 4;  endfunction
  function automatic int seedv(int d); return (d == 0) ? 7 : 127; endfunction

  int          ms [2];      // 0 idle, 1 seeding, 2 running
  int          runcyc [2];
  bit          pend [2];
  int          idx [2];
  int unsigned injn [2];
  bit          hist [2][4096];
  int          hp [2];
  exp_t        q0[$];
  exp_t        q1[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ms[d] = 0; pend[d] = 1'b0; idx[d] = 0; injn[d] = 0; runcyc[d] = 0;
    end
    q0.delete(); q1.delete();
  endtask

  // Predict what the coming clock edge does to DUT d under the current inputs
  task automatic model_edge(input int d);
    bit   emit, fb, hit, inv;
    int   per;
    exp_t e;
    per  = (1 << nlen(d)) - 1;
    emit = (ms[d] == 2) && !start && !stop && ((runcyc[d] % rdiv(d)) == 0);
    if (emit) begin
      fb = hist[d][hp[d]-1-tap_a(d)] ^ hist[d][hp[d]-1-tap_b(d)];
      hist[d][hp[d]] = fb;
      hp[d]++;
      hit = (err_period != 16'd0) && (((idx[d] + 1) % int'(err_period)) == 0);
      inv = pend[d] | err_inj | hit;
      if (inv) injn[d]++;
      e.d = fb ^ inv;
      e.s = ((idx[d] % per) == 0);
      e.t = idx[d] + 1;
      e.i = injn[d];
      e.c = cyc + 1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      idx[d]++;
      pend[d] = 1'b0;
    end else if (err_inj) begin
      pend[d] = 1'b1;
    end
    if (stop) ms[d] = 0;
    else if (start) ms[d] = 1;
    else if (ms[d] == 1) begin
      ms[d] = 2; runcyc[d] = 0; idx[d] = 0; injn[d] = 0;
      for (int p = 0; p < nlen(d); p++) hist[d][p] = seedv(d)[nlen(d)-1-p];
      hp[d] = nlen(d);
    end else if (ms[d] == 2) runcyc[d]++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (!rst && vld[d]) begin
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) chk($sformatf("dut%0d_unexpected_vld", d), 1, 0);
        else begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("dut%0d_bit_cycle", d), cyc, e.c);
          chk($sformatf("dut%0d_dout", d), dout[d], e.d);
          chk($sformatf("dut%0d_seq_start", d), seqs[d], e.s);
          chk($sformatf("dut%0d_tx_cnt", d), txc[d], e.t);
          chk($sformatf("dut%0d_inj_cnt", d), injc[d], e.i);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit s, input bit p, input bit e);
    @(negedge clk);
    #2;
    start = s; stop = p; err_inj = e;
    for (int d = 0; d < 2; d++) model_edge(d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_busy%0d", tag, d), busy[d], 0);
      chk($sformatf("%s_vld%0d", tag, d), vld[d], 0);
      chk($sformatf("%s_dout%0d", tag, d), dout[d], 0);
      chk($sformatf("%s_seq%0d", tag, d), seqs[d], 0);
      chk($sformatf("%s_tx%0d", tag, d), txc[d], 0);
      chk($sformatf("%s_inj%0d", tag, d), injc[d], 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    chk("q0_empty_at_rst", q0.size(), 0);
    chk("q1_empty_at_rst", q1.size(), 0);
    start = 0; stop = 0; err_inj = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all_zero("rst_async");
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 0; stop = 0; err_inj = 0; err_period = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #2 rst = 1'b0;
    idle(2);

    // Plain run: >2 PRBS7 periods on dut1, many PRBS3 periods on dut0
    step(1, 0, 0);
    @(posedge clk); #1;
    chk("start_busy0", busy[0], 1);
    chk("start_busy1", busy[1], 1);
    repeat (1020) step(0, 0, 0);
    chk("prbs7_bits", idx[1] >= 254, 1);
    step(0, 1, 0);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stop_busy%0d", d), busy[d], 0);
      chk($sformatf("stop_vld%0d", d), vld[d], 0);
      chk($sformatf("stop_dout%0d", d), dout[d], 0);
    end
    idle(3);
    for (int d = 0; d < 2; d++) chk($sformatf("idle_tx_hold%0d", d), txc[d], idx[d]);

    // Three err_inj pulses in IDLE collapse to a single inversion of bit 1
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1); idle(2);
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    step(0, 1, 0); idle(2);
    chk("idle_inj_cnt0", injc[0], 1);
    chk("idle_inj_cnt1", injc[1], 1);

    // Periodic inversion every 10 bits over 100 bits of dut0, err_inj on bit 20
    err_period = 16'd10;
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    step(0, 0, 1);
    repeat (80) step(0, 0, 0);
    step(0, 1, 0); idle(2);
    chk("period_tx_cnt0", txc[0], 100);
    chk("period_inj_cnt0", injc[0], 10);

    // Randomized rounds: period, single-shot injects, occasional stop/restart
    for (int r = 0; r < 6; r++) begin
      step(0, 1, 0); idle(2);
      err_period = 16'($urandom_range(0, 12));
      step(1, 0, 0);
      repeat (150)
        step($urandom_range(0, 79) == 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 9) == 0);
    end
    step(0, 1, 0); idle(2);
    err_period = 16'd0;

    // stop and start in the same RUN cycle: stop wins
    step(1, 0, 0); idle(10);
    step(1, 1, 0);
    @(posedge clk); #1;
    chk("stopstart_busy0", busy[0], 0);
    chk("stopstart_busy1", busy[1], 0);
    chk("stopstart_vld0", vld[0], 0);
    idle(3);

    // Reset mid-RUN, then restart reproduces the sequence from the seed
    step(1, 0, 0); idle(20);
    do_reset();
    idle(2);
    step(1, 0, 0); idle(60);
    step(0, 1, 0); idle(4);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
